gate_nin_debounce: RTL and testbench



---
 rtl/gate_pkg.sv | 44 ++++
 rtl/key_debounce.sv | 51 +++++
 rtl/gate_nin_debounce.sv | 59 +++++
 tb/tb_gate_nin_debounce.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared gate definitions: mode encodings and the reduction function used by
// both the gate register and any reference model.
package gate_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_XOR  = 3'd2;
    localparam logic [2:0] GATE_NAND = 3'd3;
    localparam logic [2:0] GATE_NOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;

    localparam int unsigned MAX_WIDTH = 16;

    // Reduce the low 'width' bits of vec; bits at or above 'width' are ignored.
    // Unused mode codes fall back to AND.
    function automatic logic gate_reduce(input logic [2:0]           mode,
                                         input logic [MAX_WIDTH-1:0] vec,
                                         input int unsigned          width);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic res;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                r_and = r_and & vec[i];
                r_or  = r_or  | vec[i];
                r_xor = r_xor ^ vec[i];
            end
        end
        case (mode)
            GATE_OR:   res = r_or;
            GATE_XOR:  res = r_xor;
            GATE_NAND: res = ~r_and;
            GATE_NOR:  res = ~r_or;
            GATE_XNOR: res = ~r_xor;
            default:   res = r_and;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-bit switch conditioner: 2-FF synchroniser followed by a hold-time
// debounce counter. The stable level only moves after the synchronised input
// has disagreed with it for DEB_CYCLES consecutive cycles.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic din,
    output logic din_stable
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Counter runs only while the synchronised level disagrees with the stable one.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, counter and stable level; reset discards any partial count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= din;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign din_stable = stable_q;

endmodule

// File: rtl/gate_nin_debounce.sv
// N-input selectable reduction gate behind per-bit debounced switch inputs.
// dout is registered; change_pulse marks the cycle dout takes a new value.
module gate_nin_debounce
    import gate_pkg::*;
#(
    parameter int unsigned WIDTH      = 3,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] din_stable,
    output logic             dout,
    output logic             change_pulse
);

    logic [MAX_WIDTH-1:0] vec_ext;
    logic                 dout_q, dout_d;
    logic                 change_q, change_d;
    logic                 primed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_key_debounce (
            .sys_clk    (sys_clk),
            .sys_rst_n  (sys_rst_n),
            .din        (din[i]),
            .din_stable (din_stable[i])
        );
    end

    // Gate result and change detect; primed masks the first post-reset update
    // so inverting modes do not pulse when dout leaves its reset value.
    always_comb begin
        vec_ext            = '0;
        vec_ext[WIDTH-1:0] = din_stable;
        dout_d             = gate_reduce(mode, vec_ext, WIDTH);
        change_d           = primed_q && (dout_d != dout_q);
    end

    // Output register, strobe and primed flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dout_q   <= 1'b0;
            change_q <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            change_q <= change_d;
            primed_q <= 1'b1;
        end
    end

    assign dout         = dout_q;
    assign change_pulse = change_q;

endmodule

// File: tb/tb_gate_nin_debounce.sv
module tb_gate_nin_debounce;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [2:0] mode;
    logic [2:0] din3;
    logic [4:0] din5;
    logic [2:0] stable3;
    logic [4:0] stable5;
    logic       dout3, dout5, pulse3, pulse5;

    int checks = 0;
    int errors = 0;
    int pulses3 = 0;
    int pulses5 = 0;
    int base;

    logic [7:0] exp_dout  = 8'b0010_1010; // bit m = dout for mode m with din_stable=101
    logic [7:0] exp_pulse = 8'b0111_1110; // bit m = pulse after stepping to mode m

    always #5 sys_clk = ~sys_clk;

    gate_nin_debounce #(
        .WIDTH      (3),
        .DEB_CYCLES (4)
    ) dut3 (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .din          (din3),
        .mode         (mode),
        .din_stable   (stable3),
        .dout         (dout3),
        .change_pulse (pulse3)
    );

    gate_nin_debounce #(
        .WIDTH      (5),
        .DEB_CYCLES (4)
    ) dut5 (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .din          (din5),
        .mode         (mode),
        .din_stable   (stable5),
        .dout         (dout5),
        .change_pulse (pulse5)
    );

    // Count strobes mid-cycle, clear of both clock edges.
    always @(posedge sys_clk) begin
        #2;
        if (pulse3) pulses3++;
        if (pulse5) pulses5++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        mode      = 3'd0;
        din3      = 3'b000;
        din5      = 5'b00000;
        tick(3);
        check("rst_stable", 32'(stable3), 32'h0);
        check("rst_dout", 32'(dout3), 32'h0);
        check("rst_pulse", 32'(pulse3), 32'h0);
        sys_rst_n = 1'b1;

        // 1: idle, all zero, AND
        tick(20);
        check("idle_dout", 32'(dout3), 32'h0);
        check("idle_stable", 32'(stable3), 32'h0);
        check("idle_pulses3", 32'(pulses3), 32'h0);
        check("idle_pulses5", 32'(pulses5), 32'h0);

        // 2: 000 -> 111 under AND
        din3 = 3'b111;
        tick(5);
        check("rise_stable_t5", 32'(stable3), 32'h0);
        tick(1);
        check("rise_stable_t6", 32'(stable3), 32'h7);
        check("rise_dout_t6", 32'(dout3), 32'h0);
        check("rise_pulse_t6", 32'(pulse3), 32'h0);
        tick(1);
        check("rise_dout_t7", 32'(dout3), 32'h1);
        check("rise_pulse_t7", 32'(pulse3), 32'h1);
        tick(1);
        check("rise_pulse_t8", 32'(pulse3), 32'h0);
        check("rise_pulses", 32'(pulses3), 32'h1);

        // 3: glitch of 3 cycles rejected, then 4+ cycles accepted
        base = pulses3;
        din3 = 3'b110;
        tick(3);
        din3 = 3'b111;
        tick(10);
        check("glitch_stable", 32'(stable3), 32'h7);
        check("glitch_dout", 32'(dout3), 32'h1);
        check("glitch_pulses", 32'(pulses3), 32'(base));
        din3 = 3'b110;
        tick(6);
        check("hold_stable", 32'(stable3), 32'h6);
        tick(1);
        check("hold_dout", 32'(dout3), 32'h0);
        check("hold_pulse", 32'(pulse3), 32'h1);
        tick(2);
        check("hold_pulses", 32'(pulses3), 32'(base + 1));

        // 4: mode sweep with din_stable = 101
        din3 = 3'b101;
        tick(8);
        check("sweep_stable", 32'(stable3), 32'h5);
        check("sweep_dout0", 32'(dout3), 32'h0);
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            tick(1);
            check($sformatf("sweep_dout_m%0d", m), 32'(dout3), 32'(exp_dout[m]));
            check($sformatf("sweep_pulse_m%0d", m), 32'(pulse3), 32'(exp_pulse[m]));
            tick(2);
        end

        // 5: NAND, reset mid-debounce, requalify after release
        mode = 3'd3;
        din3 = 3'b000;
        tick(8);
        check("nand_pre_stable", 32'(stable3), 32'h0);
        check("nand_pre_dout", 32'(dout3), 32'h1);
        din3 = 3'b111;
        tick(4);
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid_dout", 32'(dout3), 32'h0);
        check("rst_mid_stable", 32'(stable3), 32'h0);
        check("rst_mid_pulse", 32'(pulse3), 32'h0);
        tick(2);
        sys_rst_n = 1'b1;
        base = pulses3;
        tick(1);
        check("rel_dout_e1", 32'(dout3), 32'h1);
        check("rel_pulse_e1", 32'(pulse3), 32'h0);
        tick(1);
        check("rel_dout_e2", 32'(dout3), 32'h1);
        check("rel_pulse_e2", 32'(pulse3), 32'h0);
        tick(3);
        check("rel_stable_e5", 32'(stable3), 32'h0);
        tick(1);
        check("rel_stable_e6", 32'(stable3), 32'h7);
        tick(1);
        check("rel_dout_e7", 32'(dout3), 32'h0);
        check("rel_pulse_e7", 32'(pulse3), 32'h1);
        check("rel_pulses", 32'(pulses3), 32'(base + 1));

        // 6: WIDTH=5 parity
        mode = 3'd2;
        tick(2);
        din5 = 5'b10110;
        tick(7);
        check("par5_stable_a", 32'(stable5), 32'h16);
        check("par5_dout_a", 32'(dout5), 32'h1);
        tick(2);
        base = pulses5;
        din5 = 5'b10111;
        tick(6);
        check("par5_stable_b", 32'(stable5), 32'h17);
        check("par5_dout_b6", 32'(dout5), 32'h1);
        tick(1);
        check("par5_dout_b7", 32'(dout5), 32'h0);
        check("par5_pulse_b7", 32'(pulse5), 32'h1);
        tick(2);
        check("par5_pulses", 32'(pulses5), 32'(base + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
